md_issue_ctrl: RTL and testbench



---
 rtl/md_issue_ctrl_pkg.sv | 27 ++
 rtl/md_issue_ctrl.sv | 86 ++++++++
 tb/tb_md_issue_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared HI/LO constants: EX-stage MD class codes and the multiply/divide unit's mt* op encodings.
package md_issue_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam logic [2:0] mtMultiply  = 3'd0;
  localparam logic [2:0] mtMultiplyU = 3'd1;
  localparam logic [2:0] mtDivide    = 3'd2;
  localparam logic [2:0] mtDivideU   = 3'd3;
  localparam logic [2:0] mtSetHI     = 3'd4;
  localparam logic [2:0] mtSetLO     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl.sv
// EX-stage launcher for the HI/LO mult/div unit: one-cycle registered start pulse per op,
// combinational stall holds every MD instruction until HI/LO is quiescent; ex_stall_ext defers issue.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [3:0]       ex_mdop,
  input  logic [31:0]      ex_rs,
  input  logic [31:0]      ex_rt,
  input  logic             ex_stall_ext,
  input  logic             ex_flush,
  input  logic             md_busy,
  output logic             md_start,
  output logic [2:0]       md_ctrl,
  output logic [31:0]      md_A,
  output logic [31:0]      md_B,
  output logic             stall_md,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] ops_issued
);

  md_state_e state;
  logic      pend_calc;
  logic      is_md, is_calc, is_rd, issue;

  function automatic logic [2:0] mt_code(input logic [3:0] op);
    case (op)
      MD_MULTU: return mtMultiplyU;
      MD_DIV:   return mtDivide;
      MD_DIVU:  return mtDivideU;
      MD_MTHI:  return mtSetHI;
      MD_MTLO:  return mtSetLO;
      default:  return mtMultiply;
    endcase
  endfunction

  always_comb begin
    is_md   = ex_valid && (ex_mdop != MD_NONE);
    is_calc = (ex_mdop == MD_MULT) || (ex_mdop == MD_MULTU) ||
              (ex_mdop == MD_DIV)  || (ex_mdop == MD_DIVU);
    is_rd   = (ex_mdop == MD_MFHI) || (ex_mdop == MD_MFLO);
  end

  // mthi/mtlo also wait, so they can never race a pending result write into HI/LO.
  assign stall_md = is_md && !ex_flush && ((state != ST_IDLE) || md_busy);
  assign issue    = is_md && !is_rd && !stall_md && !ex_stall_ext && !ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pend_calc    <= 1'b0;
      md_start     <= 1'b0;
      md_ctrl      <= '0;
      md_A         <= '0;
      md_B         <= '0;
      stall_cycles <= '0;
      ops_issued   <= '0;
    end else begin
      md_start <= 1'b0;
      if (stall_md)
        stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state      <= ST_LAUNCH;
            pend_calc  <= is_calc;
            md_start   <= 1'b1;
            md_ctrl    <= mt_code(ex_mdop);
            md_A       <= ex_rs;
            md_B       <= ex_rt;
            ops_issued <= ops_issued + CNT_W'(1);
          end
        end
        // The unit samples start on the edge that ends LAUNCH; mthi/mtlo complete right there.
        ST_LAUNCH: state <= pend_calc ? ST_WAIT : ST_IDLE;
        ST_WAIT:   if (!md_busy) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl driving a behavioural HI/LO unit (multiply 5 cycles, divide 8 cycles).
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_mdop;
  logic [31:0] ex_rs, ex_rt;
  logic        ex_stall_ext, ex_flush;
  logic        md_busy;
  logic        md_start;
  logic [2:0]  md_ctrl;
  logic [31:0] md_A, md_B;
  logic        stall_md;
  logic [31:0] stall_cycles, ops_issued;

  int errors = 0;
  int checks = 0;
  int n;

  // Behavioural HI/LO unit; latency counts the launch cycle, busy covers the rest.
  logic [31:0]       hi, lo;
  int                busy_cnt;
  logic signed [63:0] prod;

  always #5 clk = ~clk;

  md_issue_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mdop(ex_mdop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_stall_ext(ex_stall_ext), .ex_flush(ex_flush),
    .md_busy(md_busy), .md_start(md_start), .md_ctrl(md_ctrl), .md_A(md_A), .md_B(md_B),
    .stall_md(stall_md), .stall_cycles(stall_cycles), .ops_issued(ops_issued)
  );

  assign md_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0; lo <= 32'h0; busy_cnt <= 0;
    end else if (md_start) begin
      case (md_ctrl)
        mtMultiply: begin
          prod = $signed({{32{md_A[31]}}, md_A}) * $signed({{32{md_B[31]}}, md_B});
          hi <= prod[63:32]; lo <= prod[31:0]; busy_cnt <= 4;
        end
        mtMultiplyU: begin
          prod = $signed({32'h0, md_A} * {32'h0, md_B});
          hi <= prod[63:32]; lo <= prod[31:0]; busy_cnt <= 4;
        end
        mtDivide: begin
          if (md_B != 0) begin
            lo <= 32'($signed(md_A) / $signed(md_B));
            hi <= 32'($signed(md_A) % $signed(md_B));
          end
          busy_cnt <= 7;
        end
        mtDivideU: begin
          if (md_B != 0) begin lo <= md_A / md_B; hi <= md_A % md_B; end
          busy_cnt <= 7;
        end
        mtSetHI: hi <= md_A;
        mtSetLO: lo <= md_A;
        default: ;
      endcase
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    ex_valid = 1'b0; ex_mdop = MD_NONE; ex_rs = 32'h0; ex_rt = 32'h0;
    ex_stall_ext = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = 1'b1; ex_mdop = op; ex_rs = rs; ex_rt = rt;
  endtask

  task automatic do_reset;
    idle_in();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    cyc(); cyc(); #1;
    check("rst_start", md_start, 0);
    check("rst_ctrl", md_ctrl, 0);
    check("rst_A", md_A, 0);
    check("rst_B", md_B, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_ops", ops_issued, 0);
    reset = 1'b0;

    // mult 7 * -3, mflo right behind it
    cyc(); set_op(MD_MULT, 32'd7, 32'hFFFF_FFFD); #1;
    check("t1_c0_stall", stall_md, 0);
    cyc(); set_op(MD_MFLO, 32'h0, 32'h0); #1;
    check("t1_c1_start", md_start, 1);
    check("t1_c1_ctrl", md_ctrl, mtMultiply);
    check("t1_c1_A", md_A, 32'd7);
    check("t1_c1_B", md_B, 32'hFFFF_FFFD);
    check("t1_c1_stall", stall_md, 1);
    check("t1_c1_ops", ops_issued, 1);
    cyc(); #1;
    check("t1_c2_start", md_start, 0);
    check("t1_c2_busy", md_busy, 1);
    n = 2;
    while (stall_md && n < 50) begin cyc(); #1; n++; end
    check("t1_release_cycle", n, 7);
    check("t1_lo", lo, 32'hFFFF_FFEB);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_stall_cycles", stall_cycles, 6);
    cyc(); idle_in(); #1;
    check("t1_ops_final", ops_issued, 1);
    check("t1_no_relaunch", md_start, 0);

    // mthi then mfhi: one LAUNCH stall
    do_reset();
    cyc(); set_op(MD_MTHI, 32'h1234_5678, 32'h0); #1;
    check("t2_c0_stall", stall_md, 0);
    cyc(); set_op(MD_MFHI, 32'h0, 32'h0); #1;
    check("t2_c1_stall", stall_md, 1);
    check("t2_c1_start", md_start, 1);
    check("t2_c1_ctrl", md_ctrl, mtSetHI);
    cyc(); #1;
    check("t2_c2_stall", stall_md, 0);
    check("t2_c2_hi", hi, 32'h1234_5678);
    check("t2_c2_stall_cycles", stall_cycles, 1);
    check("t2_c2_ops", ops_issued, 1);
    cyc(); idle_in(); #1;

    // div 100/7 then mult 3*5 stalls through the divide
    do_reset();
    cyc(); set_op(MD_DIV, 32'd100, 32'd7); #1;
    cyc(); set_op(MD_MULT, 32'd3, 32'd5); #1;
    check("t3_c1_stall", stall_md, 1);
    check("t3_c1_ctrl", md_ctrl, mtDivide);
    n = 1;
    while (stall_md && n < 50) begin
      cyc(); #1; n++;
      if (md_start) check("t3_early_start", md_start, 0);
    end
    check("t3_release_cycle", n, 10);
    check("t3_div_hi", hi, 32'd2);
    check("t3_div_lo", lo, 32'd14);
    check("t3_stall_cycles", stall_cycles, 9);
    cyc(); idle_in(); #1;
    check("t3_mult_start", md_start, 1);
    check("t3_mult_ctrl", md_ctrl, mtMultiply);
    check("t3_mult_A", md_A, 32'd3);
    check("t3_mult_B", md_B, 32'd5);
    check("t3_ops", ops_issued, 2);
    repeat (6) cyc();
    #1;
    check("t3_prod_lo", lo, 32'd15);
    check("t3_prod_hi", hi, 32'd0);

    // external stall holds a mult for 3 cycles
    do_reset();
    cyc(); set_op(MD_MULT, 32'd2, 32'd9); ex_stall_ext = 1'b1; #1;
    check("t4_c0_stall_md", stall_md, 0);
    cyc(); #1;
    check("t4_c1_start", md_start, 0);
    cyc(); #1;
    check("t4_c2_start", md_start, 0);
    cyc(); ex_stall_ext = 1'b0; #1;
    check("t4_c3_start", md_start, 0);
    cyc(); idle_in(); #1;
    check("t4_c4_start", md_start, 1);
    check("t4_c4_A", md_A, 32'd2);
    cyc(); #1;
    check("t4_c5_start", md_start, 0);
    repeat (6) cyc();
    #1;
    check("t4_ops", ops_issued, 1);
    check("t4_stall_cycles", stall_cycles, 0);
    check("t4_lo", lo, 32'd18);

    // flush kills the EX op; flush during WAIT leaves the in-flight op alone
    do_reset();
    cyc(); set_op(MD_MULT, 32'd4, 32'd4); ex_flush = 1'b1; #1;
    check("t5_flush_stall", stall_md, 0);
    cyc(); idle_in(); #1;
    check("t5_flush_start", md_start, 0);
    check("t5_flush_ops", ops_issued, 0);
    cyc(); set_op(MD_MULT, 32'd6, 32'd7); #1;
    cyc(); idle_in(); #1;
    check("t5_launch", md_start, 1);
    cyc(); set_op(MD_MFLO, 32'h0, 32'h0); ex_flush = 1'b1; #1;
    check("t5_wait_flush_stall", stall_md, 0);
    cyc(); set_op(MD_MFLO, 32'h0, 32'h0); ex_flush = 1'b0; #1;
    n = 0;
    while (stall_md && n < 50) begin cyc(); #1; n++; end
    check("t5_mflo_wait", n, 4);
    check("t5_lo", lo, 32'd42);
    check("t5_ops", ops_issued, 1);
    check("t5_stall_cycles", stall_cycles, 4);
    cyc(); idle_in(); #1;

    // reset in WAIT during a divide
    do_reset();
    cyc(); set_op(MD_DIV, 32'd100, 32'd7); #1;
    cyc(); idle_in(); #1;
    cyc(); #1;
    check("t6_busy_in_wait", md_busy, 1);
    cyc(); reset = 1'b1; #1;
    cyc(); reset = 1'b0; set_op(MD_MFHI, 32'h0, 32'h0); #1;
    check("t6_start", md_start, 0);
    check("t6_ctrl", md_ctrl, 0);
    check("t6_ops", ops_issued, 0);
    check("t6_stall_cycles", stall_cycles, 0);
    check("t6_mfhi_stall", stall_md, 0);
    cyc(); idle_in(); #1;
    check("t6_stall_cycles_after", stall_cycles, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
